// File: rtl/led_blinker_array_if.sv
// Channel configuration write port for led_blinker_array.
// LED_PHASE_SYNC_EN adds the phase-sync strobe alongside the write fields.
interface led_blinker_array_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [1:0]       wr_mode;
  logic [CNT_W-1:0] wr_half;
`ifdef LED_PHASE_SYNC_EN
  logic             sync;

  modport master (output wr_en, wr_ch, wr_mode, wr_half, sync);
  modport slave  (input  wr_en, wr_ch, wr_mode, wr_half, sync);
`else
  modport master (output wr_en, wr_ch, wr_mode, wr_half);
  modport slave  (input  wr_en, wr_ch, wr_mode, wr_half);
`endif
endinterface

// File: rtl/led_blinker_array.sv
// N_CH-channel LED blinker (OFF/ON/BLINK/BURST) on one shared prescaler tick.
// Optional LED_PHASE_SYNC_EN: cfg.sync realigns the prescaler and every channel phase.
module led_blinker_array #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 25,
  parameter int BURST_LEN = 3,
  parameter int BURST_GAP = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  led_blinker_array_if.slave    cfg,
  output logic [N_CH-1:0]       led_out,
  output logic [N_CH-1:0]       burst_done
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PLS_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GAP_W = (BURST_GAP > 1) ? $clog2(BURST_GAP) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BURST_GAP - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             sync_all;

  mode_e            mode_q  [N_CH];
  mode_e            mode_d  [N_CH];
  logic [CNT_W-1:0] half_q  [N_CH];
  logic [CNT_W-1:0] half_d  [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [PLS_W-1:0] pulse_q [N_CH];
  logic [PLS_W-1:0] pulse_d [N_CH];
  logic [GAP_W-1:0] gap_q   [N_CH];
  logic [GAP_W-1:0] gap_d   [N_CH];
  logic [N_CH-1:0]  phase_q, phase_d;
  logic [N_CH-1:0]  in_gap_q, in_gap_d;
  logic [N_CH-1:0]  enter_q, enter_d;
  logic [N_CH-1:0]  led_d;

`ifdef LED_PHASE_SYNC_EN
  assign sync_all = cfg.sync;
`else
  assign sync_all = 1'b0;
`endif

  assign tick = enable && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (sync_all)
      pre_d = '0;
    else if (enable)
      pre_d = tick ? '0 : pre_q + PRE_W'(1);

    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]   = mode_q[i];
      half_d[i]   = half_q[i];
      cnt_d[i]    = cnt_q[i];
      pulse_d[i]  = pulse_q[i];
      gap_d[i]    = gap_q[i];
      phase_d[i]  = phase_q[i];
      in_gap_d[i] = in_gap_q[i];
      enter_d[i]  = 1'b0;

      if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST) && half_q[i] != '0) begin
        if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
          cnt_d[i] = '0;
          if (!in_gap_q[i]) begin
            phase_d[i] = ~phase_q[i];
            // a burst pulse is counted when its lit half ends
            if (mode_q[i] == MODE_BURST && phase_q[i]) begin
              if (pulse_q[i] == PLS_LAST) begin
                in_gap_d[i] = 1'b1;
                gap_d[i]    = '0;
                pulse_d[i]  = '0;
                enter_d[i]  = 1'b1;
              end else begin
                pulse_d[i] = pulse_q[i] + PLS_W'(1);
              end
            end
          end else if (gap_q[i] == GAP_LAST) begin
            in_gap_d[i] = 1'b0;
            gap_d[i]    = '0;
            phase_d[i]  = 1'b1;
          end else begin
            gap_d[i] = gap_q[i] + GAP_W'(1);
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      if (sync_all) begin
        cnt_d[i]    = '0;
        pulse_d[i]  = '0;
        gap_d[i]    = '0;
        in_gap_d[i] = 1'b0;
        enter_d[i]  = 1'b0;
        phase_d[i]  = 1'b1;
      end

      // a write beats both the tick and a sync for its own channel
      if (cfg.wr_en && int'(cfg.wr_ch) == i) begin
        mode_d[i]   = mode_e'(cfg.wr_mode);
        half_d[i]   = cfg.wr_half;
        cnt_d[i]    = '0;
        pulse_d[i]  = '0;
        gap_d[i]    = '0;
        in_gap_d[i] = 1'b0;
        enter_d[i]  = 1'b0;
        phase_d[i]  = 1'b1;
      end

      led_d[i] = enable && ((mode_q[i] == MODE_ON) ||
                 (half_q[i] != '0 && phase_q[i] &&
                  ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BURST && !in_gap_q[i]))));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q      <= '0;
      mode_q     <= '{default: MODE_OFF};
      half_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      pulse_q    <= '{default: '0};
      gap_q      <= '{default: '0};
      phase_q    <= '0;
      in_gap_q   <= '0;
      enter_q    <= '0;
      led_out    <= '0;
      burst_done <= '0;
    end else begin
      pre_q      <= pre_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      gap_q      <= gap_d;
      phase_q    <= phase_d;
      in_gap_q   <= in_gap_d;
      enter_q    <= enter_d;
      led_out    <= led_d;
      burst_done <= enter_q;
    end
  end
endmodule

// File: tb/tb_led_blinker_array.sv
// Randomized bench for led_blinker_array: two instances (PRESCALE 1 and 4) share one
// config bus and are compared every cycle against a ticks-since-write reference model.
module tb_led_blinker_array;
  localparam int N_CH   = 3;
  localparam int CNT_W  = 16;
  localparam int BL     = 3;
  localparam int BG     = 4;
  localparam int CYC_HP = 2 * BL - 1 + BG;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [N_CH-1:0] led_a, bd_a, led_b, bd_b;
  int              n_chk = 0;
  int              n_fail = 0;

  led_blinker_array_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg ();

  always #5 clk = ~clk;

  led_blinker_array #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESCALE(1), .BURST_LEN(BL), .BURST_GAP(BG)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg(cfg.slave),
    .led_out(led_a), .burst_done(bd_a));

  led_blinker_array #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESCALE(4), .BURST_LEN(BL), .BURST_GAP(BG)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg(cfg.slave),
    .led_out(led_b), .burst_done(bd_b));

  // reference model: channel output is a function of ticks elapsed since its last write
  int     pres [2] = '{1, 4};
  longint en_cyc [2];
  int     m_mode [N_CH];
  longint m_half [N_CH];
  longint m_t [2][N_CH];
  bit     m_enter [2][N_CH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_led(int d, int ch);
    longint hp;
    if (m_mode[ch] == 0) return 1'b0;
    if (m_mode[ch] == 1) return 1'b1;
    if (m_half[ch] == 0) return 1'b0;
    hp = m_t[d][ch] / m_half[ch];
    if (m_mode[ch] == 2) return (hp % 2) == 0;
    hp = hp % CYC_HP;
    return (hp < 2 * BL - 1) && (hp % 2 == 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      en_cyc[d] = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        m_t[d][ch] = 0;
        m_enter[d][ch] = 1'b0;
      end
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      m_mode[ch] = 0;
      m_half[ch] = 0;
    end
  endtask

  task automatic step();
    logic [N_CH-1:0] ea, eb, ba, bb;
    bit tk;
    bit sy;
    for (int ch = 0; ch < N_CH; ch++) begin
      ea[ch] = reset_n && enable && model_led(0, ch);
      eb[ch] = reset_n && enable && model_led(1, ch);
      ba[ch] = reset_n && m_enter[0][ch];
      bb[ch] = reset_n && m_enter[1][ch];
    end
    sy = 1'b0;
`ifdef LED_PHASE_SYNC_EN
    sy = cfg.sync;
`endif
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < N_CH; ch++) m_enter[d][ch] = 1'b0;
        if (sy) begin
          en_cyc[d] = 0;
          for (int ch = 0; ch < N_CH; ch++) m_t[d][ch] = 0;
        end else if (enable) begin
          tk = (en_cyc[d] % pres[d]) == pres[d] - 1;
          en_cyc[d]++;
          if (tk) begin
            for (int ch = 0; ch < N_CH; ch++) begin
              if (m_mode[ch] >= 2 && m_half[ch] != 0) begin
                m_t[d][ch]++;
                if (m_mode[ch] == 3 && m_t[d][ch] % m_half[ch] == 0 &&
                    (m_t[d][ch] / m_half[ch]) % CYC_HP == 2 * BL - 1)
                  m_enter[d][ch] = 1'b1;
              end
            end
          end
        end
      end
      if (cfg.wr_en && cfg.wr_ch < N_CH) begin
        m_mode[cfg.wr_ch] = int'(cfg.wr_mode);
        m_half[cfg.wr_ch] = longint'(cfg.wr_half);
        for (int d = 0; d < 2; d++) begin
          m_t[d][cfg.wr_ch] = 0;
          m_enter[d][cfg.wr_ch] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("led_p1", led_a, ea);
    check_eq("done_p1", bd_a, ba);
    check_eq("led_p4", led_b, eb);
    check_eq("done_p4", bd_b, bb);
  endtask

  task automatic write_ch(input int ch, input int mode, input int half);
    cfg.wr_en = 1'b1;
    cfg.wr_ch = 2'(ch);
    cfg.wr_mode = 2'(mode);
    cfg.wr_half = CNT_W'(half);
    step();
    cfg.wr_en = 1'b0;
  endtask

  initial begin
    logic [11:0] pat12, exp12;
    logic [35:0] pat36, bd36, exp36, expbd36;
    logic [9:0]  pat10, exp10;
    int highs;
    bit seen_low;
    int halves [7] = '{0, 1, 2, 3, 5, 7, 65535};

    model_reset();
    cfg.wr_en = 1'b1;
    cfg.wr_ch = 2'd0;
    cfg.wr_mode = 2'd1;
    cfg.wr_half = 16'd3;
`ifdef LED_PHASE_SYNC_EN
    cfg.sync = 1'b0;
`endif
    reset_n = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    check_eq("rst_led", led_a, 0);
    check_eq("rst_done", bd_a, 0);
    reset_n = 1'b1;
    cfg.wr_en = 1'b0;
    repeat (3) step();
    check_eq("rst_mode_off", led_a, 0);

    // BLINK half=3 on ch0: 3 high / 3 low
    write_ch(0, 2, 3);
    pat12 = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      pat12 = {pat12[10:0], led_a[0]};
      check_eq("blink_others", led_a[2:1], 0);
    end
    exp12 = 12'b111000111000;
    check_eq("blink_pattern", pat12, exp12);

    // BURST half=2 on ch1
    write_ch(0, 0, 0);
    write_ch(1, 3, 2);
    pat36 = '0;
    bd36 = '0;
    for (int k = 0; k < 36; k++) begin
      step();
      pat36 = {pat36[34:0], led_a[1]};
      bd36 = {bd36[34:0], bd_a[1]};
    end
    exp36 = {18'b110011001100000000, 18'b110011001100000000};
    expbd36 = {18'b000000000010000000, 18'b000000000010000000};
    check_eq("burst_pattern", pat36, exp36);
    check_eq("burst_done_pos", bd36, expbd36);

    // enable freeze in the high half of BLINK half=5
    write_ch(1, 0, 0);
    write_ch(2, 2, 5);
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("freeze_dark", led_a[2], 0);
    end
    enable = 1'b1;
    highs = 0;
    seen_low = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (!seen_low && led_a[2]) highs++;
      else seen_low = 1'b1;
    end
    check_eq("resume_highs", highs, 3);

    // out-of-range channel, half=0 in BLINK
    write_ch(3, 1, 9);
    step();
    check_eq("bad_ch_ignored", led_a[0], 0);
    write_ch(0, 2, 0);
    repeat (4) step();
    check_eq("half0_dark", led_a[0], 0);

`ifdef LED_PHASE_SYNC_EN
    write_ch(0, 2, 3);
    write_ch(2, 2, 5);
    repeat (7) step();
    cfg.sync = 1'b1;
    step();
    cfg.sync = 1'b0;
    pat12 = '0;
    pat10 = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      pat12 = {pat12[10:0], led_a[0]};
      if (k < 10) pat10 = {pat10[8:0], led_a[2]};
    end
    exp12 = 12'b111000111000;
    exp10 = 10'b1111100000;
    check_eq("sync_ch0", pat12, exp12);
    check_eq("sync_ch2", pat10, exp10);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      cfg.wr_en = ($urandom_range(0, 9) == 0);
      cfg.wr_ch = 2'($urandom_range(0, 3));
      cfg.wr_mode = 2'($urandom_range(0, 3));
      cfg.wr_half = CNT_W'(halves[$urandom_range(0, 6)]);
`ifdef LED_PHASE_SYNC_EN
      cfg.sync = ($urandom_range(0, 49) == 0);
`endif
      reset_n = !(k >= 1500 && k < 1502);
      step();
    end
    cfg.wr_en = 1'b0;
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
